traffic_pattern_gen: RTL

Synthesizable, parametrised stimulus generator for energy characterization of datapath blocks such as adders. It emits bursts of PAYLOAD flits separated by GAP idle cycles, which sets a configurable link utilisation. Flits are offered on a valid/ready handshake, and each DATA_W-bit flit is split into two operand halves. It replaces fixed testbench-only pattern tables with a run-time-selectable pattern engine.

---
 rtl/traffic_pattern_gen_if.sv | 12 +
 rtl/traffic_pattern_gen.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/traffic_pattern_gen_if.sv
// Flit stream bundle for traffic_pattern_gen: valid/ready handshake carrying two N-bit operand halves.
interface traffic_pattern_gen_if #(
  parameter int N = 26
);
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_a;
  logic [N-1:0] out_b;

  modport master (output out_valid, output out_a, output out_b, input out_ready);
  modport slave  (input out_valid, input out_a, input out_b, output out_ready);
endinterface

// File: rtl/traffic_pattern_gen.sv
// Burst/gap flit generator with thermometer or Galois-LFSR data for datapath energy characterisation.
// Define STATS_EN to build the output bit-toggle counter; otherwise toggle_cnt is tied to 0.
module traffic_pattern_gen #(
  parameter int          N        = 26,
  parameter int          PAYLOAD  = 20,
  parameter int          GAP      = 7,
  parameter int          NUM_PKTS = 10,
  parameter int          STRIDE   = 10,
  parameter logic [31:0] SEED     = 32'hACE1_2468
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  traffic_pattern_gen_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           toggle_cnt
);
  localparam int DATA_W = 2 * N;
  localparam int KW     = $clog2(DATA_W + 1);
  localparam int REP    = (DATA_W + 31) / 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        r_state;
  logic              r_mode;
  logic [31:0]       r_flit;
  logic [31:0]       r_pkt;
  logic [31:0]       r_gap;
  logic              r_phase;
  logic [KW-1:0]     r_k;
  logic [31:0]       r_lfsr;
  logic [DATA_W-1:0] r_data;

  logic              w_accept, w_start_ok, w_last_flit, w_last_pkt;
  logic              w_gap_end, w_reenter, w_restart, w_step, w_mode;
  logic              w_src_phase, w_nxt_phase;
  logic [KW-1:0]     w_src_k, w_nxt_k;
  logic [31:0]       w_src_lfsr, w_nxt_lfsr, w_sum;
  logic [DATA_W-1:0] w_rep, w_ones, w_therm, w_nxt_data;

  assign w_accept    = (r_state == S_SEND) && bus.out_ready;
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last_flit = (r_flit == 32'(PAYLOAD - 1));
  assign w_last_pkt  = (r_pkt == 32'(NUM_PKTS - 1));
  assign w_gap_end   = (r_state == S_GAP) && (r_gap == 32'(GAP - 1));
  assign w_reenter   = w_accept && w_last_flit && !w_last_pkt && (GAP == 0);
  // Every entry to SEND rebuilds the pattern from its origin and steps it once in the same edge.
  assign w_restart   = w_start_ok || w_gap_end || w_reenter;
  assign w_step      = w_restart || w_accept;
  assign w_mode      = w_start_ok ? mode : r_mode;

  always_comb begin
    w_src_phase = w_restart ? 1'b0 : r_phase;
    w_src_k     = w_restart ? '0 : r_k;
    w_src_lfsr  = w_restart ? SEED : r_lfsr;
    w_sum       = 32'(w_src_k) + 32'(STRIDE);
    w_nxt_phase = w_src_phase;
    w_nxt_k     = w_src_k;
    if (!w_src_phase) begin
      if (32'(w_src_k) == 32'(DATA_W)) begin
        w_nxt_phase = 1'b1;
        w_nxt_k     = KW'(DATA_W - STRIDE);
      end else begin
        w_nxt_k = (w_sum > 32'(DATA_W)) ? KW'(DATA_W) : KW'(w_sum);
      end
    end else begin
      if (w_src_k == '0) begin
        w_nxt_phase = 1'b0;
        w_nxt_k     = KW'(STRIDE);
      end else begin
        w_nxt_k = (32'(w_src_k) <= 32'(STRIDE)) ? '0 : KW'(32'(w_src_k) - 32'(STRIDE));
      end
    end
    w_nxt_lfsr = {1'b0, w_src_lfsr[31:1]} ^ (w_src_lfsr[0] ? 32'h8020_0003 : 32'h0);
    w_rep      = DATA_W'({REP{w_nxt_lfsr}});
    w_ones     = '1;
    w_therm    = w_nxt_phase ? ~(w_ones << w_nxt_k) : ~(w_ones >> w_nxt_k);
    w_nxt_data = w_mode ? w_rep : w_therm;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_flit  <= '0;
      r_pkt   <= '0;
      r_gap   <= '0;
      r_phase <= 1'b0;
      r_k     <= '0;
      r_lfsr  <= '0;
      r_data  <= '0;
    end else begin
      if (w_step) begin
        r_phase <= w_nxt_phase;
        r_k     <= w_nxt_k;
        r_lfsr  <= w_nxt_lfsr;
        r_data  <= w_nxt_data;
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_mode  <= mode;
            r_pkt   <= '0;
            r_flit  <= '0;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_accept) begin
            if (w_last_flit) begin
              r_flit <= '0;
              if (w_last_pkt) begin
                r_state <= S_DONE;
              end else begin
                r_pkt <= r_pkt + 32'd1;
                if (GAP != 0) begin
                  r_state <= S_GAP;
                  r_gap   <= '0;
                end
              end
            end else begin
              r_flit <= r_flit + 32'd1;
            end
          end
        end
        default: begin
          if (w_gap_end) r_state <= S_SEND;
          else           r_gap   <= r_gap + 32'd1;
        end
      endcase
    end
  end

  assign bus.out_valid = (r_state == S_SEND);
  assign bus.out_a     = r_data[N-1:0];
  assign bus.out_b     = r_data[DATA_W-1:N];
  assign busy          = (r_state == S_SEND) || (r_state == S_GAP);
  assign done          = (r_state == S_DONE);

`ifdef STATS_EN
  logic [DATA_W-1:0] r_prev;
  logic [31:0]       r_tog;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= '0;
      r_tog  <= '0;
    end else if (w_start_ok) begin
      r_prev <= '0;
      r_tog  <= '0;
    end else if (w_accept) begin
      r_tog  <= r_tog + 32'($countones(r_data ^ r_prev));
      r_prev <= r_data;
    end
  end

  assign toggle_cnt = r_tog;
`else
  assign toggle_cnt = '0;
`endif
endmodule
